// File: rtl/vproc_bus_arbiter_if.sv
// rtl/vproc_bus_arbiter_if.sv - VProc memory-mapped bus bundle, N ports packed side by side
interface vproc_bus_arbiter_if #(
  parameter int N = 1
);
  logic [32*N-1:0] Addr;
  logic [4*N-1:0]  BE;
  logic [N-1:0]    WE;
  logic [N-1:0]    RD;
  logic [32*N-1:0] DataOut;
  logic [12*N-1:0] Burst;
  logic [N-1:0]    BurstFirst;
  logic [N-1:0]    BurstLast;
  logic [32*N-1:0] DataIn;
  logic [N-1:0]    WRAck;
  logic [N-1:0]    RDAck;

  modport master (
    output Addr, BE, WE, RD, DataOut, Burst, BurstFirst, BurstLast,
    input  DataIn, WRAck, RDAck
  );

  modport slave (
    input  Addr, BE, WE, RD, DataOut, Burst, BurstFirst, BurstLast,
    output DataIn, WRAck, RDAck
  );
endinterface

// File: rtl/vproc_bus_arbiter.sv
// rtl/vproc_bus_arbiter.sv - round-robin arbiter sharing one slave between NUM_MASTERS VProc masters
// Optional watchdog built when VPROC_ARB_TIMEOUT_EN is defined.
module vproc_bus_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int IDX_WIDTH      = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  vproc_bus_arbiter_if.slave    i_m_bus,
  vproc_bus_arbiter_if.master   o_s_bus,
  output logic                  o_busy,
  output logic [IDX_WIDTH-1:0]  o_gnt_idx,
  output logic                  o_error
);

  if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || (2**IDX_WIDTH) < NUM_MASTERS || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("vproc_bus_arbiter: illegal parameter combination");
  end

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_HOLDOFF} state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [IDX_WIDTH-1:0]   r_gnt_idx;
  logic [IDX_WIDTH-1:0]   r_last;
  logic [IDX_WIDTH-1:0]   w_pick;
  logic [NUM_MASTERS-1:0] w_req;
  logic                   w_any_req;
  logic                   w_grant;
  logic                   w_ack;
  logic                   w_done;
  logic                   w_timeout;

  logic [31:0] w_g_addr;
  logic [3:0]  w_g_be;
  logic        w_g_we;
  logic        w_g_rd;
  logic [31:0] w_g_dout;
  logic [11:0] w_g_burst;
  logic        w_g_first;
  logic        w_g_last;
  logic        w_g_req;

  assign w_req     = i_m_bus.RD | i_m_bus.WE;
  assign w_any_req = |w_req;
  assign w_grant   = (r_state == S_GRANT);

  // Walk from the furthest candidate back to Last+1 so the nearest requester wins.
  always_comb begin : rr_pick
    int idx;
    idx    = 0;
    w_pick = '0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      idx = (int'(r_last) + k) % NUM_MASTERS;
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (i == idx && w_req[i]) w_pick = IDX_WIDTH'(i);
      end
    end
  end

  always_comb begin : slave_mux
    w_g_addr  = '0;
    w_g_be    = '0;
    w_g_we    = 1'b0;
    w_g_rd    = 1'b0;
    w_g_dout  = '0;
    w_g_burst = '0;
    w_g_first = 1'b0;
    w_g_last  = 1'b0;
    w_g_req   = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (w_grant && int'(r_gnt_idx) == i) begin
        w_g_addr  = i_m_bus.Addr[32*i +: 32];
        w_g_be    = i_m_bus.BE[4*i +: 4];
        w_g_we    = i_m_bus.WE[i];
        w_g_rd    = i_m_bus.RD[i];
        w_g_dout  = i_m_bus.DataOut[32*i +: 32];
        w_g_burst = i_m_bus.Burst[12*i +: 12];
        w_g_first = i_m_bus.BurstFirst[i];
        w_g_last  = i_m_bus.BurstLast[i];
        w_g_req   = w_req[i];
      end
    end
  end

  assign o_s_bus.Addr       = w_g_addr;
  assign o_s_bus.BE         = w_g_be;
  assign o_s_bus.WE         = w_g_we;
  assign o_s_bus.RD         = w_g_rd;
  assign o_s_bus.DataOut    = w_g_dout;
  assign o_s_bus.Burst      = w_g_burst;
  assign o_s_bus.BurstFirst = w_g_first;
  assign o_s_bus.BurstLast  = w_g_last;

  assign w_ack  = (w_g_we & o_s_bus.WRAck) | (w_g_rd & o_s_bus.RDAck);
  // A master that drops its strobes unacked releases the bus rather than hanging it.
  assign w_done = w_grant & (w_timeout | (w_ack & ((w_g_burst == 12'd0) | w_g_last)) | ~w_g_req);

  always_comb begin : resp_route
    i_m_bus.DataIn = '0;
    i_m_bus.WRAck  = '0;
    i_m_bus.RDAck  = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (w_grant && int'(r_gnt_idx) == i) begin
        if (w_timeout) begin
          i_m_bus.DataIn[32*i +: 32] = 32'hDEADBEEF;
          i_m_bus.WRAck[i]           = w_g_we;
          i_m_bus.RDAck[i]           = w_g_rd;
        end else begin
          i_m_bus.DataIn[32*i +: 32] = o_s_bus.DataIn;
          i_m_bus.WRAck[i]           = o_s_bus.WRAck;
          i_m_bus.RDAck[i]           = o_s_bus.RDAck;
        end
      end
    end
  end

`ifdef VPROC_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] r_wd;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wd <= '0;
    end else if (!w_grant || w_ack || w_timeout) begin
      r_wd <= '0;
    end else begin
      r_wd <= r_wd + 1'b1;
    end
  end

  assign w_timeout = w_grant && (r_wd == WD_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_gnt_idx <= '0;
      r_last    <= IDX_WIDTH'(NUM_MASTERS - 1);
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_any_req) begin
        r_gnt_idx <= w_pick;
        r_last    <= w_pick;
      end
    end
  end

  always_comb begin : next_state
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_any_req) w_next = S_GRANT;
      S_GRANT:   if (w_done) w_next = S_HOLDOFF;
      S_HOLDOFF: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  assign o_busy    = w_grant;
  assign o_gnt_idx = r_gnt_idx;
  assign o_error   = w_timeout;

endmodule

// File: tb/tb_vproc_bus_arbiter.sv
// tb/tb_vproc_bus_arbiter.sv - directed and randomized self-checking bench for vproc_bus_arbiter
module tb_vproc_bus_arbiter;
  localparam int NM = 4;
  localparam int IW = 3;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          busy;
  logic          err;
  logic [IW-1:0] gnt;
  int            errors = 0;
  int            checks = 0;

  vproc_bus_arbiter_if #(.N(NM)) m_bus ();
  vproc_bus_arbiter_if #(.N(1))  s_bus ();

  vproc_bus_arbiter #(
    .NUM_MASTERS(NM), .IDX_WIDTH(IW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_m_bus(m_bus), .o_s_bus(s_bus),
    .o_busy(busy), .o_gnt_idx(gnt), .o_error(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int i, input logic we, input logic rd, input logic [31:0] a,
                       input logic [31:0] d, input logic [11:0] b, input logic bf, input logic bl);
    m_bus.WE[i]               = we;
    m_bus.RD[i]               = rd;
    m_bus.Addr[32*i +: 32]    = a;
    m_bus.DataOut[32*i +: 32] = d;
    m_bus.BE[4*i +: 4]        = 4'hF;
    m_bus.Burst[12*i +: 12]   = b;
    m_bus.BurstFirst[i]       = bf;
    m_bus.BurstLast[i]        = bl;
  endtask

  task automatic clear_all();
    for (int i = 0; i < NM; i++) set_m(i, 1'b0, 1'b0, 32'h0, 32'h0, 12'h0, 1'b0, 1'b0);
    s_bus.DataIn = '0;
    s_bus.WRAck  = 1'b0;
    s_bus.RDAck  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_all();
    #1;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  // Reference arbitration: first requester after the last grant, in rotation order.
  function automatic int rr_pick(input logic [NM-1:0] req, input int last);
    for (int k = 1; k <= NM; k++) begin
      if (req[(last + k) % NM]) return (last + k) % NM;
    end
    return -1;
  endfunction

  initial begin
    logic [NM-1:0] req_prev;
    logic [31:0]   addr_q [NM];
    logic [31:0]   data_q [NM];
    logic          we_q   [NM];
    logic          act    [NM];
    int            wg     [NM];
    int            mlast, wait_cnt, acked_m, grants, prev_rise, nrise, err_cnt, err_at;
    logic          pb, pb2;

    // Reset state
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_err", err, 0);
    chk("rst_we", s_bus.WE, 0);
    chk("rst_rd", s_bus.RD, 0);
    chk("rst_addr", s_bus.Addr, 0);

    // Single read from master 1
    set_m(1, 1'b0, 1'b1, 32'h100, 32'h0, 12'h0, 1'b0, 1'b0);
    #1;
    chk("t1_rd_before_edge", s_bus.RD, 0);
    step();
    chk("t1_rd", s_bus.RD, 1);
    chk("t1_addr", s_bus.Addr, 32'h100);
    chk("t1_gnt", gnt, 1);
    chk("t1_busy", busy, 1);
    chk("t1_no_ack_yet", m_bus.RDAck, 0);
    step();
    s_bus.DataIn = 32'h12345678;
    s_bus.RDAck  = 1'b1;
    #1;
    chk("t1_mdata", m_bus.DataIn[63:32], 32'h12345678);
    chk("t1_mrdack", m_bus.RDAck, 4'b0010);
    chk("t1_other_data", m_bus.DataIn[31:0], 0);
    step();
    chk("t1_holdoff_busy", busy, 0);
    chk("t1_holdoff_rd", s_bus.RD, 0);
    chk("t1_holdoff_ack", m_bus.RDAck, 0);
    step();
    chk("t1_no_stale_regrant", busy, 0);
    chk("t1_gnt_hold", gnt, 1);
    clear_all();

    // Continuous writes from masters 0 and 1, immediate acks
    do_reset();
    set_m(0, 1'b1, 1'b0, 32'h10, 32'h1, 12'h0, 1'b0, 1'b0);
    set_m(1, 1'b1, 1'b0, 32'h20, 32'h2, 12'h0, 1'b0, 1'b0);
    s_bus.WRAck = 1'b1;
    pb = 1'b0;
    prev_rise = -1;
    nrise = 0;
    for (int c = 0; c < 13; c++) begin
      step();
      if (busy && !pb) begin
        chk("t2_alt_gnt", gnt, nrise % 2);
        chk("t2_alt_addr", s_bus.Addr, (nrise % 2) ? 32'h20 : 32'h10);
        if (prev_rise >= 0) chk("t2_gap", c - prev_rise, 3);
        prev_rise = c;
        nrise++;
      end
      pb = busy;
    end
    chk("t2_grant_count", nrise, 5);
    clear_all();

    // 4-word write burst from master 0 while master 1 waits
    do_reset();
    set_m(1, 1'b1, 1'b0, 32'h300, 32'hB0, 12'h0, 1'b0, 1'b0);
    set_m(0, 1'b1, 1'b0, 32'h200, 32'hA0, 12'd4, 1'b1, 1'b0);
    s_bus.WRAck = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      set_m(0, 1'b1, 1'b0, 32'h200 + k, 32'hA0 + k, 12'd4, k == 0, k == 3);
      #1;
      chk("t3_addr", s_bus.Addr, 32'h200 + k);
      chk("t3_data", s_bus.DataOut, 32'hA0 + k);
      chk("t3_gnt", gnt, 0);
      chk("t3_busy", busy, 1);
      chk("t3_first", s_bus.BurstFirst, k == 0);
      chk("t3_burst", s_bus.Burst, 4);
      step();
    end
    chk("t3_holdoff", busy, 0);
    chk("t3_holdoff_we", s_bus.WE, 0);
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 12'h0, 1'b0, 1'b0);
    step();
    chk("t3_idle", busy, 0);
    step();
    chk("t3_next_gnt", gnt, 1);
    chk("t3_next_addr", s_bus.Addr, 32'h300);
    clear_all();

    // Reset asserted mid-burst
    do_reset();
    set_m(0, 1'b1, 1'b0, 32'h200, 32'hA0, 12'd4, 1'b1, 1'b0);
    s_bus.WRAck = 1'b1;
    step();
    step();
    set_m(0, 1'b1, 1'b0, 32'h201, 32'hA1, 12'd4, 1'b0, 1'b0);
    step();
    set_m(0, 1'b1, 1'b0, 32'h202, 32'hA2, 12'd4, 1'b0, 1'b0);
    #1;
    chk("t4_mid_burst_we", s_bus.WE, 1);
    rst = 1'b1;
    #1;
    chk("t4_async_we", s_bus.WE, 0);
    chk("t4_async_rd", s_bus.RD, 0);
    chk("t4_async_ack", m_bus.WRAck, 0);
    chk("t4_async_busy", busy, 0);
    clear_all();
    step();
    rst = 1'b0;
    step();
    chk("t4_busy", busy, 0);
    chk("t4_gnt", gnt, 0);
    set_m(0, 1'b1, 1'b0, 32'h40, 32'h0, 12'h0, 1'b0, 1'b0);
    set_m(3, 1'b1, 1'b0, 32'h70, 32'h0, 12'h0, 1'b0, 1'b0);
    step();
    chk("t4_restart_gnt", gnt, 0);
    clear_all();

    // Unacknowledged read from master 2
    do_reset();
    set_m(2, 1'b0, 1'b1, 32'h500, 32'h0, 12'h0, 1'b0, 1'b0);
    step();
    chk("t5_gnt", gnt, 2);
`ifdef VPROC_ARB_TIMEOUT_EN
    err_cnt = 0;
    err_at  = -1;
    for (int c = 1; c <= 20; c++) begin
      if (err) begin
        err_cnt++;
        err_at = c;
        chk("t5_to_rdack", m_bus.RDAck, 4'b0100);
        chk("t5_to_data", m_bus.DataIn[95:64], 32'hDEADBEEF);
      end
      if (c == 17) chk("t5_to_holdoff", busy, 0);
      step();
    end
    chk("t5_err_count", err_cnt, 1);
    chk("t5_err_cycle", err_at, TO);
`else
    err_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (err) err_cnt++;
      step();
    end
    chk("t5_busy_stuck", busy, 1);
    chk("t5_gnt_stuck", gnt, 2);
    chk("t5_no_err", err_cnt, 0);
    chk("t5_no_ack", m_bus.RDAck, 0);
`endif
    set_m(2, 1'b0, 1'b0, 32'h0, 32'h0, 12'h0, 1'b0, 1'b0);
    step();
    step();
    step();

    // Stray acks while idle
    chk("t6_idle", busy, 0);
    s_bus.RDAck  = 1'b1;
    s_bus.WRAck  = 1'b1;
    s_bus.DataIn = 32'hCAFEF00D;
    #1;
    chk("t6_rdack", m_bus.RDAck, 0);
    chk("t6_wrack", m_bus.WRAck, 0);
    chk("t6_data", m_bus.DataIn, 0);
    step();
    step();
    chk("t6_busy", busy, 0);
    chk("t6_gnt", gnt, 2);
    s_bus.RDAck = 1'b0;
    s_bus.WRAck = 1'b0;
    set_m(1, 1'b1, 1'b0, 32'h11, 32'h0, 12'h0, 1'b0, 1'b0);
    set_m(3, 1'b1, 1'b0, 32'h33, 32'h0, 12'h0, 1'b0, 1'b0);
    step();
    chk("t6_pointer", gnt, rr_pick(4'b1010, 2));
    clear_all();

    // Randomized traffic against the rotation model
    do_reset();
    mlast    = NM - 1;
    req_prev = '0;
    pb       = 1'b0;
    pb2      = 1'b0;
    acked_m  = -1;
    wait_cnt = 0;
    grants   = 0;
    for (int i = 0; i < NM; i++) begin
      act[i] = 1'b0;
      wg[i]  = 0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      step();
      if (acked_m >= 0) begin
        chk("rnd_done", busy, 0);
        set_m(acked_m, 1'b0, 1'b0, 32'h0, 32'h0, 12'h0, 1'b0, 1'b0);
        act[acked_m] = 1'b0;
        acked_m = -1;
      end
      if (busy && !pb) begin
        int eg;
        eg = rr_pick(req_prev, mlast);
        chk("rnd_gnt", gnt, eg);
        chk("rnd_holdoff", pb2, 0);
        if (eg >= 0) begin
          chk("rnd_wait_bound", wg[eg] <= NM - 1, 1);
          for (int i = 0; i < NM; i++) begin
            if (i == eg) wg[i] = 0;
            else if (req_prev[i]) wg[i]++;
          end
          mlast = eg;
        end
        wait_cnt = $urandom_range(0, 2);
        grants++;
      end
      for (int i = 0; i < NM; i++) begin
        if (!act[i] && $urandom_range(0, 3) == 0) begin
          act[i]    = 1'b1;
          we_q[i]   = 1'($urandom_range(0, 1));
          addr_q[i] = $urandom;
          data_q[i] = $urandom;
          set_m(i, we_q[i], !we_q[i], addr_q[i], data_q[i], 12'h0, 1'b0, 1'b0);
        end
      end
      s_bus.WRAck  = 1'b0;
      s_bus.RDAck  = 1'b0;
      s_bus.DataIn = $urandom;
      if (busy) begin
        chk("rnd_s_addr", s_bus.Addr, addr_q[gnt]);
        chk("rnd_s_we", s_bus.WE, we_q[gnt]);
        chk("rnd_s_rd", s_bus.RD, !we_q[gnt]);
        if (we_q[gnt]) chk("rnd_s_dout", s_bus.DataOut, data_q[gnt]);
        if (wait_cnt == 0) begin
          if (we_q[gnt]) s_bus.WRAck = 1'b1;
          else           s_bus.RDAck = 1'b1;
          acked_m = int'(gnt);
          #1;
          if (we_q[acked_m]) chk("rnd_wrack", m_bus.WRAck, NM'(1) << acked_m);
          else begin
            chk("rnd_rdack", m_bus.RDAck, NM'(1) << acked_m);
            chk("rnd_rdata", m_bus.DataIn[32*acked_m +: 32], s_bus.DataIn);
          end
        end else begin
          wait_cnt--;
        end
      end else begin
        s_bus.WRAck = 1'($urandom_range(0, 1));
        s_bus.RDAck = 1'($urandom_range(0, 1));
        #1;
        chk("rnd_idle_acks", {m_bus.WRAck, m_bus.RDAck}, 0);
      end
      req_prev = m_bus.WE | m_bus.RD;
      pb2 = pb;
      pb  = busy;
    end
    chk("rnd_grant_activity", grants > 20, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vproc_bus_arbiter.md
Name: vproc_bus_arbiter

Overview:
- Shares one downstream memory-mapped slave between NUM_MASTERS VProc bus masters.
- Masters connect via packed vectors of the VProc bus signals (Addr, BE, WE, RD, DataOut, Burst, BurstFirst, BurstLast).
- Round-robin arbitration; a grant is held for a whole single access or a whole burst.
- Slave DataIn and acks are routed back to the granted master only.

Parameters:
- NUM_MASTERS, 2: number of VProc masters, legal range 2..8.
- IDX_WIDTH, 3: width of the GntIdx output; must satisfy 2**IDX_WIDTH >= NUM_MASTERS.
- TIMEOUT_CYCLES, 1024: watchdog limit in Clk cycles; used only with VPROC_ARB_TIMEOUT_EN.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Reset  in  1  asynchronous, active-high reset.
- MAddr  in  32*NUM_MASTERS  master addresses; master i occupies bits [32i+31:32i].
- MBE  in  4*NUM_MASTERS  master byte enables.
- MWE  in  NUM_MASTERS  master write strobes.
- MRD  in  NUM_MASTERS  master read strobes.
- MDataOut  in  32*NUM_MASTERS  master write data.
- MBurst  in  12*NUM_MASTERS  master burst counts.
- MBurstFirst  in  NUM_MASTERS  master first-of-burst flags.
- MBurstLast  in  NUM_MASTERS  master last-of-burst flags.
- MDataIn  out  32*NUM_MASTERS  read data returned to masters.
- MWRAck  out  NUM_MASTERS  per-master write acks.
- MRDAck  out  NUM_MASTERS  per-master read acks.
- Addr, BE, WE, RD, DataOut, Burst, BurstFirst, BurstLast  out  32,4,1,1,32,12,1,1  slave-side bus.
- DataIn  in  32  slave read data.
- WRAck  in  1  slave write ack.
- RDAck  in  1  slave read ack.
- Busy  out  1  a grant is active.
- GntIdx  out  IDX_WIDTH  index of the granted master; holds the last grant when idle.
- Error  out  1  one-cycle pulse on watchdog expiry.

Behaviour:
- Request: master i requests when MRD[i] | MWE[i].
- State machine: IDLE, GRANT, HOLDOFF.
- Reset (asynchronous): state IDLE, Busy=0, GntIdx=0, rotation pointer Last=NUM_MASTERS-1, watchdog=0, Error=0.
  - Slave WE/RD are 0 and all MWRAck/MRDAck are 0 immediately on reset assertion, including mid-access.
- IDLE:
  - On posedge with any request: grant the first requester searching Last+1, Last+2, ... modulo NUM_MASTERS.
  - Register GntIdx, set Last=GntIdx and Busy=1, go to GRANT.
  - With no request: stay in IDLE.
  - Latency: a request sampled at edge n is visible on the slave bus after edge n.
- GRANT:
  - All slave outputs are a combinational mux of the granted master's signals.
  - Slave DataIn, WRAck and RDAck are combinationally forwarded to the granted master only.
  - All other masters see MWRAck=0, MRDAck=0, MDataIn=0.
- Completion: ack = (WE & WRAck) | (RD & RDAck), sampled at posedge.
  - Burst==0: the first ack completes the access.
  - Burst!=0: the grant is kept across all words; the ack sampled while BurstLast=1 completes it.
  - A single-word burst (Burst=1, BurstFirst=BurstLast=1) completes on its one ack.
- On completion: go to HOLDOFF, Busy=0.
- HOLDOFF:
  - Lasts exactly one cycle, then IDLE.
  - Purpose: the just-acked master's strobes are still asserted when sampled at the completion edge; they must not be re-arbitrated stale.
- No-grant outputs: while not in GRANT, slave WE=RD=0 and BurstFirst=BurstLast=0; Addr, BE, DataOut and Burst are driven 0.
- A granted master dropping both strobes without an ack (illegal VProc behaviour) returns the arbiter to HOLDOFF.
- Simultaneous requests: resolved purely by the rotation order; no master waits more than NUM_MASTERS-1 grants.
- Acks arriving in IDLE or HOLDOFF are ignored.

Optional Feature:
- Macro: VPROC_ARB_TIMEOUT_EN.
- Defined:
  - Watchdog counts cycles in GRANT and clears on every ack.
  - When it reaches TIMEOUT_CYCLES: pulse Error for 1 cycle.
  - In that same cycle, assert the granted master's MWRAck or MRDAck (matching its strobe) with MDataIn=32'hDEADBEEF.
  - Then go to HOLDOFF, which also aborts the remainder of any burst.
- Undefined: no watchdog logic is built, Error is tied 0, and the arbiter waits in GRANT indefinitely.

Test Plan:
- Reset then idle: master 1 requests a read of Addr 0x100, slave returns DataIn 0x12345678 with RDAck after 2 cycles → RD on the slave one cycle after the request; master 1 sees MDataIn=0x12345678 with MRDAck; GntIdx=1; then HOLDOFF, then IDLE.
- Masters 0 and 1 issue writes continuously, slave acks immediately → grants alternate 0,1,0,1 with exactly one HOLDOFF cycle between grants; no master is starved.
- Master 0 issues a 4-word write burst from Addr 0x200 while master 1 requests → master 1 is not granted until after the ack with BurstLast=1; the slave sees 4 words at 0x200..0x203.
- Reset asserted mid-burst (after 2 of 4 words) → slave WE and RD go 0 asynchronously; after release, GntIdx=0, Busy=0, and the next request is granted starting from master 0.
- With VPROC_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave never acks a read from master 2 → after 16 GRANT cycles, Error pulses once and master 2 gets MRDAck with 0xDEADBEEF; without the macro, Busy stays 1.
- Slave pulses RDAck while in IDLE with no grant → no master sees an ack, and state and pointer are unchanged.
